// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with clock-enable prescaler, parallel load and wrap pulse.
// Define BCD_CNT_SAT_EN to add the sat_mode port and run-time selectable saturation at the limits.
module bcd_updown_counter #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 1_000_000
) (
   input  logic                clk,
   input  logic                reset_p,
   input  logic                enable,
   input  logic                up_down,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_value,
`ifdef BCD_CNT_SAT_EN
   input  logic                sat_mode,
`endif
   output logic [4*DIGITS-1:0] count,
   output logic                tick,
   output logic                carry,
   output logic                at_limit
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

   logic [4*DIGITS-1:0] count_q, count_d;
   logic [PW-1:0]       psc_q, psc_d;
   logic                carry_q, carry_d;

   logic [4*DIGITS-1:0] step_cnt;
   logic [3:0]          dig;
   logic                cy;
   logic                all_nines, all_zeros;
   logic                sat_hold;

   // Digits above 9 are not valid BCD; pin them to 9 so the display never shows garbage.
   function automatic logic [4*DIGITS-1:0] clamp_bcd(input logic [4*DIGITS-1:0] v);
      logic [4*DIGITS-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
      end
      return r;
   endfunction

   always_comb begin
      all_nines = 1'b1;
      all_zeros = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (count_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
         if (count_q[4*i +: 4] != 4'd0) all_zeros = 1'b0;
      end
   end

   assign at_limit = up_down ? all_nines : all_zeros;

`ifdef BCD_CNT_SAT_EN
   assign sat_hold = sat_mode & at_limit;
`else
   assign sat_hold = 1'b0;
`endif

   assign tick = enable & (psc_q == PSC_LAST) & ~reset_p & ~load;

   // Ripple the +1/-1 through the digits; the whole word still updates on one edge.
   always_comb begin
      step_cnt = count_q;
      cy       = 1'b1;
      dig      = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         dig = count_q[4*i +: 4];
         if (cy) begin
            if (up_down) begin
               if (dig == 4'd9) begin
                  dig = 4'd0;
                  cy  = 1'b1;
               end else begin
                  dig = dig + 4'd1;
                  cy  = 1'b0;
               end
            end else begin
               if (dig == 4'd0) begin
                  dig = 4'd9;
                  cy  = 1'b1;
               end else begin
                  dig = dig - 4'd1;
                  cy  = 1'b0;
               end
            end
         end
         step_cnt[4*i +: 4] = dig;
      end
   end

   always_comb begin
      count_d = count_q;
      psc_d   = psc_q;
      carry_d = 1'b0;
      if (load) begin
         count_d = clamp_bcd(load_value);
         psc_d   = '0;
      end else if (enable) begin
         psc_d = (psc_q == PSC_LAST) ? '0 : psc_q + 1'b1;
         if (tick && !sat_hold) begin
            count_d = step_cnt;
            carry_d = at_limit;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset_p) begin
         count_q <= '0;
         psc_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         count_q <= count_d;
         psc_q   <= psc_d;
         carry_q <= carry_d;
      end
   end

   assign count = count_q;
   assign carry = carry_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter with DIGITS=2, PRESCALE=3.
module tb_bcd_updown_counter;

   logic       clk = 1'b0;
   logic       reset_p, enable, up_down, load, sat_mode;
   logic [7:0] load_value;
   logic [7:0] count;
   logic       tick, carry, at_limit;
   int         n_tests = 0;
   int         n_fail  = 0;

   bcd_updown_counter #(.DIGITS(2), .PRESCALE(3)) dut (
      .clk        (clk),
      .reset_p    (reset_p),
      .enable     (enable),
      .up_down    (up_down),
      .load       (load),
      .load_value (load_value),
`ifdef BCD_CNT_SAT_EN
      .sat_mode   (sat_mode),
`endif
      .count      (count),
      .tick       (tick),
      .carry      (carry),
      .at_limit   (at_limit)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_p = 1'b1; enable = 1'b1; up_down = 1'b1; load = 1'b0;
      load_value = 8'h00; sat_mode = 1'b0;
      step(); step();
      n_tests++; if (count !== 8'h00) begin n_fail++; $display("FAIL reset_count got %h exp 00", count); end
      n_tests++; if (carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry got %b exp 0", carry); end
      step();
      n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b exp 0", tick); end
      n_tests++; if (at_limit !== 1'b0) begin n_fail++; $display("FAIL reset_atlim_up got %b exp 0", at_limit); end
      up_down = 1'b0; #1;
      n_tests++; if (at_limit !== 1'b1) begin n_fail++; $display("FAIL reset_atlim_dn got %b exp 1", at_limit); end
      up_down = 1'b1;
      reset_p = 1'b0;
   endtask

   task automatic test_count_up();
      logic [7:0] exp;
      for (int k = 1; k <= 10; k++) begin
         exp = 8'(((k / 10) << 4) | (k % 10));
         step();
         n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL up_tick_idle k=%0d got %b exp 0", k, tick); end
         step();
         n_tests++; if (tick !== 1'b1) begin n_fail++; $display("FAIL up_tick k=%0d got %b exp 1", k, tick); end
         step();
         n_tests++; if (count !== exp) begin n_fail++; $display("FAIL up_count k=%0d got %h exp %h", k, count, exp); end
         n_tests++; if (carry !== 1'b0) begin n_fail++; $display("FAIL up_carry k=%0d got %b exp 0", k, carry); end
      end
   endtask

   task automatic test_enable_hold();
      step();
      enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         n_tests++; if (tick !== 1'b0 || count !== 8'h10) begin
            n_fail++; $display("FAIL hold i=%0d got tick=%b count=%h exp tick=0 count=10", i, tick, count);
         end
      end
      enable = 1'b1;
      step();
      n_tests++; if (tick !== 1'b1) begin n_fail++; $display("FAIL hold_resume_tick got %b exp 1", tick); end
      step();
      n_tests++; if (count !== 8'h11) begin n_fail++; $display("FAIL hold_resume_count got %h exp 11", count); end
   endtask

   task automatic test_wrap_up();
      load = 1'b1; load_value = 8'h98;
      #1;
      n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL wup_load_tick got %b exp 0", tick); end
      step();
      load = 1'b0;
      n_tests++; if (count !== 8'h98) begin n_fail++; $display("FAIL wup_load got %h exp 98", count); end
      step(); step(); step();
      n_tests++; if (count !== 8'h99 || carry !== 1'b0) begin
         n_fail++; $display("FAIL wup_99 got count=%h carry=%b exp 99/0", count, carry);
      end
      n_tests++; if (at_limit !== 1'b1) begin n_fail++; $display("FAIL wup_atlim got %b exp 1", at_limit); end
      step(); step(); step();
      n_tests++; if (count !== 8'h00 || carry !== 1'b1) begin
         n_fail++; $display("FAIL wup_wrap got count=%h carry=%b exp 00/1", count, carry);
      end
      step();
      n_tests++; if (carry !== 1'b0) begin n_fail++; $display("FAIL wup_carry_len got %b exp 0", carry); end
      n_tests++; if (count !== 8'h00) begin n_fail++; $display("FAIL wup_after got %h exp 00", count); end
   endtask

   task automatic test_wrap_down();
      load = 1'b1; load_value = 8'h00; up_down = 1'b0;
      step();
      load = 1'b0;
      n_tests++; if (at_limit !== 1'b1) begin n_fail++; $display("FAIL wdn_atlim got %b exp 1", at_limit); end
      step(); step(); step();
      n_tests++; if (count !== 8'h99 || carry !== 1'b1) begin
         n_fail++; $display("FAIL wdn_wrap got count=%h carry=%b exp 99/1", count, carry);
      end
      step();
      n_tests++; if (carry !== 1'b0) begin n_fail++; $display("FAIL wdn_carry_len got %b exp 0", carry); end
      step(); step();
      n_tests++; if (count !== 8'h98 || carry !== 1'b0) begin
         n_fail++; $display("FAIL wdn_98 got count=%h carry=%b exp 98/0", count, carry);
      end
   endtask

   task automatic test_load_on_tick();
      step(); step();
      n_tests++; if (tick !== 1'b1) begin n_fail++; $display("FAIL lot_pretick got %b exp 1", tick); end
      load = 1'b1; load_value = 8'hA5;
      #1;
      n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL lot_tick_masked got %b exp 0", tick); end
      step();
      load = 1'b0;
      n_tests++; if (count !== 8'h95 || carry !== 1'b0) begin
         n_fail++; $display("FAIL lot_clamp got count=%h carry=%b exp 95/0", count, carry);
      end
      step();
      n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL lot_early_tick got %b exp 0", tick); end
      step();
      n_tests++; if (tick !== 1'b1) begin n_fail++; $display("FAIL lot_next_tick got %b exp 1", tick); end
      step();
      n_tests++; if (count !== 8'h94) begin n_fail++; $display("FAIL lot_step got %h exp 94", count); end
      load = 1'b1; load_value = 8'hBF;
      step();
      load = 1'b0;
      n_tests++; if (count !== 8'h99) begin n_fail++; $display("FAIL lot_clamp_both got %h exp 99", count); end
   endtask

   task automatic test_reset_on_tick();
      up_down = 1'b1; load = 1'b1; load_value = 8'h47;
      step();
      load = 1'b0;
      step(); step();
      n_tests++; if (tick !== 1'b1 || count !== 8'h47) begin
         n_fail++; $display("FAIL rot_pre got tick=%b count=%h exp 1/47", tick, count);
      end
      reset_p = 1'b1;
      #1;
      n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL rot_tick_masked got %b exp 0", tick); end
      step();
      reset_p = 1'b0;
      n_tests++; if (count !== 8'h00 || carry !== 1'b0) begin
         n_fail++; $display("FAIL rot_clear got count=%h carry=%b exp 00/0", count, carry);
      end
      step();
      n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL rot_psc1 got %b exp 0", tick); end
      step();
      n_tests++; if (tick !== 1'b1) begin n_fail++; $display("FAIL rot_psc2 got %b exp 1", tick); end
      step();
      n_tests++; if (count !== 8'h01) begin n_fail++; $display("FAIL rot_step got %h exp 01", count); end
   endtask

`ifdef BCD_CNT_SAT_EN
   task automatic test_saturate();
      sat_mode = 1'b1; up_down = 1'b1; load = 1'b1; load_value = 8'h99;
      step();
      load = 1'b0;
      for (int t = 0; t < 3; t++) begin
         step(); step(); step();
         n_tests++; if (count !== 8'h99 || carry !== 1'b0 || at_limit !== 1'b1) begin
            n_fail++; $display("FAIL sat t=%0d got count=%h carry=%b atlim=%b exp 99/0/1", t, count, carry, at_limit);
         end
      end
      up_down = 1'b0; #1;
      n_tests++; if (at_limit !== 1'b0) begin n_fail++; $display("FAIL sat_dir_atlim got %b exp 0", at_limit); end
      step(); step(); step();
      n_tests++; if (count !== 8'h98) begin n_fail++; $display("FAIL sat_down got %h exp 98", count); end
      sat_mode = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_count_up();
      test_enable_hold();
      test_wrap_up();
      test_wrap_down();
      test_load_on_tick();
      test_reset_on_tick();
`ifdef BCD_CNT_SAT_EN
      test_saturate();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit BCD up/down counter with a built-in clock-enable prescaler, synchronous parallel load, and a wrap/carry indication. It succeeds the fixed 4-bit binary up/down counters. It sits between the system clock and the FND display path: `count` feeds the per-digit 7-segment decoders directly, one nibble per digit. All state is updated synchronously on `clk`; there are no derived or ripple clocks.

## Interface
Parameters:
- `DIGITS`, default 4: number of BCD digits; `count` width is 4*DIGITS.
- `PRESCALE`, default 1_000_000: `clk` cycles per count step, ≥1. The prescaler register is $clog2(PRESCALE) bits wide, minimum 1.

Ports:
- `clk`, input, 1: the single system clock; all logic on its rising edge.
- `reset_p`, input, 1: synchronous, active-high reset.
- `enable`, input, 1: prescaler runs only while high.
- `up_down`, input, 1: 1 = count up, 0 = count down; sampled on tick cycles.
- `load`, input, 1: synchronous parallel load.
- `load_value`, input, 4*DIGITS: BCD value to load; digit 0 in [3:0].
- `sat_mode`, input, 1: 1 = saturate, 0 = wrap. Present only with `BCD_CNT_SAT_EN`.
- `count`, output, 4*DIGITS: registered BCD count.
- `tick`, output, 1: step strobe, combinational.
- `carry`, output, 1: registered one-cycle wrap pulse.
- `at_limit`, output, 1: combinational; high when `count` is all 9s with `up_down`=1, or all 0s with `up_down`=0.

## Operation
- Priority on every edge: `reset_p` > `load` > step.
- Reset: `count`=0, prescaler=0, `carry`=0. `tick`=0 while `reset_p` is high.
- Prescaler:
  - While `enable`=1 and not loading, counts 0..PRESCALE-1 and wraps to 0.
  - `tick` = `enable` & (prescaler==PRESCALE-1) & ~`reset_p` & ~`load`.
  - While `enable`=0, the prescaler holds its value.
  - With PRESCALE=1, `tick`=`enable` (gated as above).
- Load:
  - `count` ← `load_value`.
  - Any digit >9 is clamped to 9.
  - Prescaler cleared to 0; `carry` ← 0.
  - Load ignores `enable`.
- Step (on a `tick` cycle):
  - Up: digit 0 +1; a digit at 9 becomes 0 and carries into the next digit.
  - Down: digit 0 −1; a digit at 0 becomes 9 and borrows from the next digit.
  - All digits update on the same edge.
- Wrap:
  - Up from all 9s → all 0s, `carry`=1.
  - Down from all 0s → all 9s, `carry`=1.
- Saturate (`sat_mode`=1, macro only): a step at the limit leaves `count` unchanged and `carry`=0.
- `carry` is 0 on every edge other than a wrapping step.
- A direction change takes effect on the next tick; no reset of the prescaler.

## Timing
- `tick` is asserted in cycle k. `count` takes its new value after the rising edge ending cycle k, visible in cycle k+1.
- `carry` is high for exactly cycle k+1, aligned with the wrapped `count`.
- Step latency from `enable` rising with the prescaler at 0: the first `tick` occurs PRESCALE-1 cycles later. Subsequent ticks are every PRESCALE enabled cycles.
- Load: `count` = loaded value in the next cycle. The first tick after a load with `enable` held is PRESCALE cycles after the load cycle.
- Reset mid-count (including on a tick cycle): next cycle `count`=0 and `carry`=0; the pending step is discarded.
- `at_limit` follows `count` and `up_down` combinationally, with no added latency.

## Configuration
- `BCD_CNT_SAT_EN` defined:
  - The `sat_mode` port exists.
  - Saturate behaviour is selectable at run time.
  - `at_limit` is valid in both modes.
- Not defined:
  - No `sat_mode` port; the counter always wraps.
  - `at_limit` is still generated.
  - No saturate logic is synthesised.

## Test plan
All scenarios use DIGITS=2, PRESCALE=3.
- Reset, then `enable`=1, `up_down`=1 → ticks every 3rd cycle; `count` 0x00,0x01,…,0x09,0x10 (BCD digit carry, never 0x0A).
- Load 0x98, up → after two ticks `count`=0x99 then 0x00; `carry`=1 for exactly the cycle `count` shows 0x00.
- Load 0x00, `up_down`=0 → one tick → `count`=0x99, `carry` pulses once. Next tick → 0x98, `carry`=0.
- Assert `load` with `load_value`=0xA5 in a would-be tick cycle → `count`=0x95 next cycle with no step applied. The next tick comes 3 cycles after the load.
- `BCD_CNT_SAT_EN`, `sat_mode`=1: load 0x99, up, 3 ticks → `count` stays 0x99, `carry`=0, `at_limit`=1. Switch to `up_down`=0 → `at_limit`=0, next tick gives 0x98.
- `reset_p` high for one cycle coinciding with a tick while `count`=0x47 → next cycle `count`=0x00, `carry`=0, prescaler restarts from 0.
